reg_bank_rw: RTL
================

# reg_bank_rw

Parametrised dual-write-port register bank for the SuperIO register space. It holds DEPTH words of WIDTH bits and has two write ports: a bus port with byte enables and a hardware-status port. It also provides a registered read port, per-entry dirty tracking with an interrupt output, and a sequential bulk-clear engine. It sits between the ISA bus decode and the device-state logic, replacing ad-hoc single-word two-source registers.

## Interface
- WIDTH, 32, word width; must be a multiple of 8
- DEPTH, 8, number of entries; must be ≥2; AW = $clog2(DEPTH) is derived, not a parameter
- RESET_VAL, 0, value loaded into every entry on reset and on bulk clear
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- addr  in  AW  bus write address
- D  in  WIDTH  bus write data
- be  in  WIDTH/8  bus byte enables, active-high
- wr_n  in  1  bus write strobe, active-low
- haddr  in  AW  hardware write address
- D2  in  WIDTH  hardware write data (full word)
- hw_wr_n  in  1  hardware write strobe, active-low
- raddr  in  AW  read address
- rd_n  in  1  read strobe, active-low
- clr_n  in  1  bulk-clear request, active-low, level-sampled
- Q  out  WIDTH  registered read data
- q_valid  out  1  one-cycle pulse when Q is updated
- dirty  out  DEPTH  per-entry "written by hardware, unread" flags
- irq  out  1  registered interrupt
- busy  out  1  bulk clear in progress

## Operation
- Reset (reset low, asynchronous) sets every entry to RESET_VAL and returns the state to IDLE.
  - Outputs: Q=0, q_valid=0, dirty=0, irq=0, busy=0, sweep index=0.
- Writes are applied in IDLE only.
  - Bus write, wr_n low: bytes with be[i]=1 load D bytes; other bytes hold.
  - be=0 with wr_n low is a no-op.
- Hardware write, hw_wr_n low: the full word loads D2 and sets dirty[haddr].
- Simultaneous writes to different addresses: both apply in the same cycle.
- Simultaneous writes to the same address: merge per byte.
  - Bytes with be set take D.
  - Remaining bytes take D2.
  - dirty is set.
- Read, rd_n low: Q <= entry[raddr] (pre-write value if written the same cycle); q_valid=1 for that cycle.
  - The read clears dirty[raddr].
  - A hardware write to the same entry in the same cycle wins: dirty stays 1.
- Q holds its value when there is no read.
- irq <= |dirty (see Configuration).
- FSM states:
  - IDLE → SWEEP when clr_n is low in IDLE; the sweep index is set to 0.
  - SWEEP: each cycle, entry[idx] <= RESET_VAL, dirty[idx] <= 0, idx++. At idx == DEPTH-1 that entry is cleared and the FSM returns to IDLE.
- During SWEEP:
  - busy=1.
  - Bus and hardware writes are dropped, not queued.
  - Reads are served; a read of an already-swept entry returns RESET_VAL.
  - clr_n is ignored.
  - If clr_n is still low on return to IDLE, a new sweep starts the next cycle.
- Reset asserted mid-sweep aborts the sweep immediately; all state takes its reset values.

## Timing
- Write-to-storage: 1 cycle; a read issued the cycle after a write returns the new data.
- Read latency: 1 cycle, rd_n sampled at edge N → Q/q_valid valid after edge N.
- dirty updates at the write or read edge; irq lags dirty by one cycle.
- Bulk clear takes exactly DEPTH cycles.
  - busy is high from the edge after clr_n is sampled to the edge after the last entry clears.
  - The first write accepted is in the cycle busy is low.
- The strobes are synchronous and sampled every edge; a strobe held low for k cycles performs k operations.

## Configuration
- REG_BANK_IRQ_MASK_EN
  - Defined: adds input irq_mask [DEPTH-1:0], active-high, and irq <= |(dirty & irq_mask). Dirty tracking is unchanged.
  - Undefined: no irq_mask port; irq <= |dirty.

## Structure
- Package reg_bank_pkg:
  - state typedef (IDLE, SWEEP).
  - Localparam BYTE=8.
  - A function returning the byte count for a width.
- Sub-module reg_bank_byte_merge, combinational: (D, be, D2, bus_hit, hw_hit, old) → next word.
  - It is instantiated per entry and is the single place where merge priority is defined.
- Top level holds storage, the dirty vector, the read register, and the sweep FSM/index counter.

## Test plan
- Reset, then read all 8 entries → Q=0x00000000 each, q_valid pulses 8 times, dirty=0, irq=0.
- Bus write addr=2, D=0xAABBCCDD, be=0b0101, then read 2 → Q=0x00BB00DD.
- Same cycle: bus addr=3, D=0x11111111, be=0b0011, and hw haddr=3, D2=0x22222222.
  - Required: read 3 → 0x22221111.
  - Required: dirty[3]=1; irq=1 one cycle after dirty.
- Hardware write 5 with a simultaneous read of 5 → Q returns the old value and dirty[5] stays 1.
  - A second read → new value, and dirty[5]=0.
- With entries 0..7 non-zero, pulse clr_n for 1 cycle; write addr=1 during the sweep.
  - Required: busy high for 8 cycles.
  - Required: the write is dropped and all entries read 0 afterwards.
- Assert reset at sweep cycle 3 → busy=0 and state IDLE immediately; all entries are RESET_VAL; Q=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types, constants and helpers for the reg_bank register bank.
package reg_bank_pkg;

  localparam int BYTE = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  function automatic int byte_count(input int width);
    return width / BYTE;
  endfunction

endpackage

// File: rtl/reg_bank_byte_merge.sv
// Next-word merge for one entry: bus bytes with be set win, remaining bytes
// take the hardware word when it hits this entry, otherwise the old value holds.
module reg_bank_byte_merge
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             d_i,
  input  logic [byte_count(WIDTH)-1:0] be_i,
  input  logic [WIDTH-1:0]             d2_i,
  input  logic                         bus_hit_i,
  input  logic                         hw_hit_i,
  input  logic [WIDTH-1:0]             old_i,
  output logic [WIDTH-1:0]             next_o
);

  localparam int NB = byte_count(WIDTH);

  // Byte-wise priority: bus (enabled byte) > hardware > hold.
  always_comb begin
    next_o = old_i;
    for (int i = 0; i < NB; i++) begin
      if (bus_hit_i && be_i[i]) begin
        next_o[i*BYTE +: BYTE] = d_i[i*BYTE +: BYTE];
      end else if (hw_hit_i) begin
        next_o[i*BYTE +: BYTE] = d2_i[i*BYTE +: BYTE];
      end else begin
        next_o[i*BYTE +: BYTE] = old_i[i*BYTE +: BYTE];
      end
    end
  end

endmodule

// File: rtl/reg_bank_rw.sv
// Dual-write-port register bank with dirty tracking, registered read and a sequential bulk clear.
// Optional REG_BANK_IRQ_MASK_EN adds an irq_mask input gating the interrupt per entry.
module reg_bank_rw
  import reg_bank_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(DEPTH)-1:0]     addr,
  input  logic [WIDTH-1:0]             D,
  input  logic [byte_count(WIDTH)-1:0] be,
  input  logic                         wr_n,
  input  logic [$clog2(DEPTH)-1:0]     haddr,
  input  logic [WIDTH-1:0]             D2,
  input  logic                         hw_wr_n,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  input  logic                         rd_n,
  input  logic                         clr_n,
`ifdef REG_BANK_IRQ_MASK_EN
  input  logic [DEPTH-1:0]             irq_mask,
`endif
  output logic [WIDTH-1:0]             Q,
  output logic                         q_valid,
  output logic [DEPTH-1:0]             dirty,
  output logic                         irq,
  output logic                         busy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] mem_q    [DEPTH];
  logic [WIDTH-1:0] mem_d    [DEPTH];
  logic [WIDTH-1:0] merged_s [DEPTH];
  logic [DEPTH-1:0] bus_hit_s, hw_hit_s, irq_src_s;
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q, irq_q, busy_q;
  logic             wr_en_s;

  // Writes are only accepted outside a sweep; dropped otherwise.
  assign wr_en_s = (state_q == IDLE);

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    assign bus_hit_s[k] = wr_en_s && !wr_n    && (addr  == AW'(k));
    assign hw_hit_s[k]  = wr_en_s && !hw_wr_n && (haddr == AW'(k));

    reg_bank_byte_merge #(.WIDTH(WIDTH)) u_merge (
      .d_i      (D),
      .be_i     (be),
      .d2_i     (D2),
      .bus_hit_i(bus_hit_s[k]),
      .hw_hit_i (hw_hit_s[k]),
      .old_i    (mem_q[k]),
      .next_o   (merged_s[k])
    );
  end

`ifdef REG_BANK_IRQ_MASK_EN
  assign irq_src_s = dirty_q & irq_mask;
`else
  assign irq_src_s = dirty_q;
`endif

  // Sweep FSM: one entry cleared per cycle, back to IDLE after the last one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!clr_n) begin
          state_d = SWEEP;
          idx_d   = {AW{1'b0}};
        end else begin
          state_d = IDLE;
          idx_d   = idx_q;
        end
      end
      SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = {AW{1'b0}};
        end else begin
          state_d = SWEEP;
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {AW{1'b0}};
      end
    endcase
  end

  // Next storage and dirty: sweep clears, a read clears dirty, a hardware write re-sets it last.
  always_comb begin
    dirty_d = dirty_q;
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k] = merged_s[k];
      if ((state_q == SWEEP) && (idx_q == AW'(k))) begin
        mem_d[k]   = RESET_VAL;
        dirty_d[k] = 1'b0;
      end else begin
        mem_d[k] = merged_s[k];
      end
      if (!rd_n && (raddr == AW'(k))) begin
        dirty_d[k] = 1'b0;
      end else begin
        dirty_d[k] = dirty_d[k];
      end
      if (hw_hit_s[k]) begin
        dirty_d[k] = 1'b1;
      end else begin
        dirty_d[k] = dirty_d[k];
      end
    end
  end

  // State, storage and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= {AW{1'b0}};
      dirty_q   <= {DEPTH{1'b0}};
      q_q       <= {WIDTH{1'b0}};
      q_valid_q <= 1'b0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= RESET_VAL;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      q_valid_q <= !rd_n;
      irq_q     <= |irq_src_s;
      busy_q    <= (state_d == SWEEP);
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
      if (!rd_n) begin
        q_q <= mem_q[raddr];
      end else begin
        q_q <= q_q;
      end
    end
  end

  assign Q       = q_q;
  assign q_valid = q_valid_q;
  assign dirty   = dirty_q;
  assign irq     = irq_q;
  assign busy    = busy_q;

endmodule
